// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: fetches one block from IRAM word by word and writes it into the cache.
// Optional ICACHE_CRIT_WORD_FIRST_EN: request the missing word first, then wrap through the block.
module icache_refill_ctrl #(
    parameter int BLOCK_SIZE = 128,
    parameter int WORD_SIZE  = 32,
    parameter int PC_SIZE    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [PC_SIZE-1:0]   pc,
    output logic                 mem_req,
    output logic [PC_SIZE-1:0]   mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [0:BLOCK_SIZE-1] block_out,
    output logic                 we,
    output logic                 stall
);

    localparam int NWORDS = BLOCK_SIZE / WORD_SIZE;
    localparam int OFFS   = $clog2(BLOCK_SIZE / 8);
    localparam int WOFF   = $clog2(WORD_SIZE / 8);
    localparam int IDXW   = OFFS - WOFF;
    localparam int CNTW   = $clog2(NWORDS + 1);
    localparam int NBYTES = WORD_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [IDXW-1:0]     idx;
    logic [IDXW-1:0]     idx_inc;
    logic [IDXW-1:0]     start_idx;
    logic [CNTW-1:0]     cnt;
    logic [PC_SIZE-OFFS-1:0] base_hi;
    logic                last_word;
    logic                unused_pc;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign start_idx = pc[OFFS-1:WOFF];
    assign unused_pc = ^pc[WOFF-1:0];
`else
    assign start_idx = '0;
    assign unused_pc = ^pc[OFFS-1:0];
`endif

    assign idx_inc   = (idx == IDXW'(NWORDS - 1)) ? '0 : idx + IDXW'(1);
    assign last_word = (cnt == CNTW'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs are gated by rst so a held reset never shows a stall or request.
    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        we      = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                stall = miss & ~rst;
                if (miss) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                stall   = ~rst;
                mem_req = ~rst;
                if (mem_ack && last_word) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                we      = ~rst;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Each byte lands in the big-endian-indexed block so byte j of the block is block_out[8j +: 8].
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            base_hi   <= '0;
            mem_addr  <= '0;
            block_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        base_hi  <= pc[PC_SIZE-1:OFFS];
                        idx      <= start_idx;
                        cnt      <= '0;
                        mem_addr <= {pc[PC_SIZE-1:OFFS], start_idx, {WOFF{1'b0}}};
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        for (int unsigned k = 0; k < NBYTES; k++) begin
                            block_out[WORD_SIZE*32'(idx) + 8*k +: 8] <= mem_rdata[8*k +: 8];
                        end
                        idx <= idx_inc;
                        cnt <= cnt + CNTW'(1);
                        if (!last_word) begin
                            mem_addr <= {base_hi, idx_inc, {WOFF{1'b0}}};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: reset, zero-wait and wait-state refills, reset abort.
module tb_icache_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         miss;
    logic [31:0]  pc;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [0:127] block_out;
    logic         we;
    logic         stall;
    logic [7:0]   seed;

    int unsigned errors = 0;
    int unsigned checks = 0;

    icache_refill_ctrl #(
        .BLOCK_SIZE(128),
        .WORD_SIZE (32),
        .PC_SIZE   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .miss     (miss),
        .pc       (pc),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .block_out(block_out),
        .we       (we),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IRAM contents: byte at block offset j holds seed + j.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata[8*i +: 8] = seed + {4'b0, mem_addr[3:2], 2'b00} + 8'(i);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refill(input string nm, input logic [31:0] pc_v, input logic [7:0] seed_v,
                          input int unsigned waits, input bit toggle,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0]  ea [4];
        logic [0:127] eb;
        int unsigned  total;
        int unsigned  word;
        int unsigned  phase;
        ea = '{a0, a1, a2, a3};
        for (int j = 0; j < 16; j++) eb[8*j +: 8] = seed_v + 8'(j);
        total = 4 * (waits + 1) + 1;
        seed  = seed_v;
        pc    = pc_v;
        for (int unsigned c = 0; c <= total + 1; c++) begin
            word  = (c >= 1) ? (c - 1) / (waits + 1) : 0;
            phase = (c >= 1) ? (c - 1) % (waits + 1) : 0;
            mem_ack = (c == 0) || (c < total && phase == waits);
            if (c == 0)          miss = 1'b1;
            else if (c < total)  miss = toggle ? c[0] : 1'b1;
            else                 miss = 1'b0;
            @(negedge clk);
            chk($sformatf("%s stall c%0d", nm, c), 128'(stall), 128'(c < total));
            chk($sformatf("%s req c%0d", nm, c), 128'(mem_req), 128'(c >= 1 && c < total));
            chk($sformatf("%s we c%0d", nm, c), 128'(we), 128'(c == total));
            if (c >= 1 && c < total)
                chk($sformatf("%s addr c%0d", nm, c), 128'(mem_addr), 128'(ea[word]));
            if (c == total) begin
                chk($sformatf("%s block", nm), 128'(block_out), 128'(eb));
                chk($sformatf("%s byte0", nm), 128'(block_out[0:7]), 128'(seed_v));
                chk($sformatf("%s byte1", nm), 128'(block_out[8:15]), 128'(seed_v + 8'd1));
                chk($sformatf("%s byte4", nm), 128'(block_out[32:39]), 128'(seed_v + 8'd4));
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] b0, b1, b2, b3;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
        b0 = 32'h1018; b1 = 32'h101C; b2 = 32'h1010; b3 = 32'h1014;
`else
        b0 = 32'h1010; b1 = 32'h1014; b2 = 32'h1018; b3 = 32'h101C;
`endif
        // Reset held with miss and ack asserted.
        rst = 1'b1; miss = 1'b1; mem_ack = 1'b1; pc = 32'h1018; seed = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst req c%0d", c), 128'(mem_req), 128'(0));
            chk($sformatf("rst we c%0d", c), 128'(we), 128'(0));
            chk($sformatf("rst stall c%0d", c), 128'(stall), 128'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0; miss = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst stall", 128'(stall), 128'(0));
        chk("post_rst req", 128'(mem_req), 128'(0));
        chk("post_rst addr", 128'(mem_addr), 128'(0));
        chk("post_rst block", 128'(block_out), 128'(0));
        @(posedge clk); #1;

        // Zero-wait refill, data pattern 0x03020100, 0x07060504, ...
        refill("zw", 32'h0000_1018, 8'h00, 0, 1'b0, b0, b1, b2, b3);

        // Three wait states per word, miss toggled during FETCH.
        refill("ws3", 32'h0000_1018, 8'h40, 3, 1'b1, b0, b1, b2, b3);

        // Reset after the second ack aborts the refill.
        seed = 8'h10; pc = 32'h1018; miss = 1'b1; mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort req", 128'(mem_req), 128'(0));
        chk("abort we", 128'(we), 128'(0));
        chk("abort stall", 128'(stall), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0; miss = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_after we c%0d", c), 128'(we), 128'(0));
            chk($sformatf("abort_after req c%0d", c), 128'(mem_req), 128'(0));
            chk($sformatf("abort_after stall c%0d", c), 128'(stall), 128'(0));
            chk($sformatf("abort_after addr c%0d", c), 128'(mem_addr), 128'(0));
            chk($sformatf("abort_after block c%0d", c), 128'(block_out), 128'(0));
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;

        refill("pc20", 32'h0000_0020, 8'h80, 0, 1'b0,
               32'h20, 32'h24, 32'h28, 32'h2C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
